com_pixel_feeder: RTL and testbench

- Producer end of the centroid pixel interface.
- Scans an incoming raster luma stream, thresholds each pixel and tracks raster coordinates.
- Emits one (x,y,valid) beat per qualifying pixel, then a single tabulate pulse at frame end.
- Holds off all further output until the centroid block reports its result; sits between the camera/luma pipeline and the centre-of-mass unit.

---
 rtl/com_pixel_feeder_pkg.sv | 19 +
 rtl/com_pixel_feeder_coord.sv | 75 +++++++
 rtl/com_pixel_feeder.sv | 171 +++++++++++++++++
 tb/tb_com_pixel_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pixel_feeder_pkg.sv
// Shared definitions for the centroid pixel interface: feeder FSM states,
// coordinate widths and a saturating counter helper.
package com_pixel_feeder_pkg;

  localparam int X_WIDTH = 11;
  localparam int Y_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_TAB  = 2'd2,
    ST_WAIT = 2'd3
  } feeder_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/com_pixel_feeder_coord.sv
// Raster coordinate tracker: gives the coordinate of the pixel being presented
// this cycle and whether it lies inside the active area.
module raster_coord_tracker
  import com_pixel_feeder_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               pixel_valid_in,
  input  logic               frame_start_in,
  input  logic               line_start_in,
  output logic [X_WIDTH-1:0] x_out,
  output logic [Y_WIDTH-1:0] y_out,
  output logic               in_area_out,
  output logic               last_out
);

  localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(H_ACTIVE - 1);
  localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(V_ACTIVE - 1);

  logic [X_WIDTH-1:0] r_x, w_x;
  logic [Y_WIDTH-1:0] r_y, w_y;
  logic               r_y_ovf, w_y_ovf, w_x_ovf;

  // x stays parked at X_MAX, so any further pixel on that line is overflow;
  // an overflow line is sticky until the next frame start.
  always_comb begin
    w_x     = r_x;
    w_y     = r_y;
    w_x_ovf = 1'b0;
    w_y_ovf = r_y_ovf;
    if (frame_start_in) begin
      w_x     = '0;
      w_y     = '0;
      w_y_ovf = 1'b0;
    end else if (line_start_in) begin
      w_x = '0;
      if (r_y == Y_MAX) begin
        w_y_ovf = 1'b1;
      end else begin
        w_y = r_y + Y_WIDTH'(1);
      end
    end else begin
      if (r_x == X_MAX) begin
        w_x_ovf = 1'b1;
      end else begin
        w_x = r_x + X_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x     <= '0;
      r_y     <= '0;
      r_y_ovf <= 1'b0;
    end else if (pixel_valid_in) begin
      r_x     <= w_x;
      r_y     <= w_y;
      r_y_ovf <= w_y_ovf;
    end else begin
      r_x     <= r_x;
      r_y     <= r_y;
      r_y_ovf <= r_y_ovf;
    end
  end

  assign x_out       = w_x;
  assign y_out       = w_y;
  assign in_area_out = !w_x_ovf && !w_y_ovf;
  assign last_out    = in_area_out && (w_x == X_MAX) && (w_y == Y_MAX);

endmodule

// File: rtl/com_pixel_feeder.sv
// Producer side of the centroid pixel interface: thresholds a raster luma
// stream, emits qualifying pixel coordinates and a tabulate pulse per frame.
module com_pixel_feeder
  import com_pixel_feeder_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int LUMA_WIDTH = 8,
  parameter int MIN_PIXELS = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [LUMA_WIDTH-1:0] luma_in,
  input  logic                  pixel_valid_in,
  input  logic                  frame_start_in,
  input  logic                  line_start_in,
  input  logic [LUMA_WIDTH-1:0] threshold_in,
  input  logic                  com_valid_in,
  output logic [X_WIDTH-1:0]    x_out,
  output logic [Y_WIDTH-1:0]    y_out,
  output logic                  valid_out,
  output logic                  tabulate_out,
  output logic                  empty_frame_out,
  output logic [31:0]           pixel_count_out,
  output logic                  busy_out
);

  if (H_ACTIVE > 2048) begin : g_h_range
    $error("H_ACTIVE must not exceed 2048");
  end
  if (V_ACTIVE > 1024) begin : g_v_range
    $error("V_ACTIVE must not exceed 1024");
  end

  logic [X_WIDTH-1:0] w_px;
  logic [Y_WIDTH-1:0] w_py;
  logic               w_in_area, w_is_last;

  raster_coord_tracker #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_coord (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .pixel_valid_in(pixel_valid_in),
    .frame_start_in(frame_start_in),
    .line_start_in (line_start_in),
    .x_out         (w_px),
    .y_out         (w_py),
    .in_area_out   (w_in_area),
    .last_out      (w_is_last)
  );

  feeder_state_t         r_state, w_state_nxt;
  logic [LUMA_WIDTH-1:0] r_thresh, w_thresh_nxt, w_thresh_eff;
  logic [31:0]           r_fcount, w_fcount_nxt, w_base, w_cnt, w_count_nxt;
  logic                  w_eval, w_trunc, w_qual, w_end;
  logic                  w_valid_nxt, w_tab_nxt, w_empty_pend_nxt, w_busy_nxt;
  logic [X_WIDTH-1:0]    w_x_nxt;
  logic [Y_WIDTH-1:0]    w_y_nxt;
  logic                  r_empty_pend;

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_thresh_nxt     = r_thresh;
    w_thresh_eff     = r_thresh;
    w_base           = r_fcount;
    w_eval           = 1'b0;
    w_trunc          = 1'b0;
    w_tab_nxt        = 1'b0;
    w_empty_pend_nxt = 1'b0;
    w_valid_nxt      = 1'b0;
    w_x_nxt          = x_out;
    w_y_nxt          = y_out;
    w_count_nxt      = pixel_count_out;
    w_fcount_nxt     = r_fcount;
    case (r_state)
      ST_IDLE: begin
        if (pixel_valid_in && frame_start_in) begin
          w_thresh_nxt = threshold_in;
          w_thresh_eff = threshold_in;
          w_base       = 32'd0;
          w_eval       = 1'b1;
          w_state_nxt  = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (pixel_valid_in && frame_start_in) begin
          w_trunc = 1'b1;
        end else begin
          w_eval = pixel_valid_in;
        end
      end
      ST_TAB: begin
        w_tab_nxt   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (com_valid_in) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_qual = w_eval && w_in_area && (luma_in >= w_thresh_eff);
    w_cnt  = w_qual ? sat_inc32(w_base) : w_base;
    if (w_qual) begin
      w_valid_nxt = 1'b1;
      w_x_nxt     = w_px;
      w_y_nxt     = w_py;
    end else begin
      w_valid_nxt = 1'b0;
    end
    if (w_eval) begin
      w_fcount_nxt = w_cnt;
    end else begin
      w_fcount_nxt = r_fcount;
    end

    // A truncated frame ends without evaluating the new frame-start pixel.
    w_end = w_trunc || (w_eval && w_is_last);
    if (w_end) begin
      w_count_nxt = w_cnt;
      if (w_cnt >= 32'(MIN_PIXELS)) begin
        w_state_nxt = ST_TAB;
      end else begin
        w_state_nxt      = ST_IDLE;
        w_empty_pend_nxt = 1'b1;
      end
    end else begin
      w_count_nxt = pixel_count_out;
    end
    w_busy_nxt = (w_state_nxt == ST_TAB) || (w_state_nxt == ST_WAIT);
  end

  // State, frame bookkeeping and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state         <= ST_IDLE;
      r_thresh        <= '0;
      r_fcount        <= 32'd0;
      r_empty_pend    <= 1'b0;
      valid_out       <= 1'b0;
      x_out           <= '0;
      y_out           <= '0;
      tabulate_out    <= 1'b0;
      empty_frame_out <= 1'b0;
      pixel_count_out <= 32'd0;
      busy_out        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_thresh        <= w_thresh_nxt;
      r_fcount        <= w_fcount_nxt;
      r_empty_pend    <= w_empty_pend_nxt;
      valid_out       <= w_valid_nxt;
      x_out           <= w_x_nxt;
      y_out           <= w_y_nxt;
      tabulate_out    <= w_tab_nxt;
      empty_frame_out <= r_empty_pend;
      pixel_count_out <= w_count_nxt;
      busy_out        <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_com_pixel_feeder.sv
// Directed self-checking bench for com_pixel_feeder on a 4x3 raster.
module tb_com_pixel_feeder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  luma_in = 8'd0;
  logic        pixel_valid_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        line_start_in = 1'b0;
  logic [7:0]  threshold_in = 8'd0;
  logic        com_valid_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out, tabulate_out, empty_frame_out, busy_out;
  logic [31:0] pixel_count_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  com_pixel_feeder #(
    .H_ACTIVE(4), .V_ACTIVE(3), .LUMA_WIDTH(8), .MIN_PIXELS(1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .luma_in(luma_in),
    .pixel_valid_in(pixel_valid_in), .frame_start_in(frame_start_in),
    .line_start_in(line_start_in), .threshold_in(threshold_in),
    .com_valid_in(com_valid_in), .x_out(x_out), .y_out(y_out),
    .valid_out(valid_out), .tabulate_out(tabulate_out),
    .empty_frame_out(empty_frame_out), .pixel_count_out(pixel_count_out),
    .busy_out(busy_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
    line_start_in  = 1'b0;
    luma_in        = 8'd0;
  endtask

  // Pixel i is at x=i%4, y=i/4. lmask picks hi/lo luma; emask lists expected beats.
  task automatic drive_frame(input logic [7:0] hi, input logic [7:0] lo,
                             input logic [11:0] lmask, input logic [11:0] emask,
                             input logic [7:0] thr0, input logic [7:0] thr1,
                             input int npix);
    for (int i = 0; i < npix; i++) begin
      pixel_valid_in = 1'b1;
      frame_start_in = (i == 0);
      line_start_in  = (i != 0) && (i % 4 == 0);
      luma_in        = lmask[i] ? hi : lo;
      threshold_in   = (i < 6) ? thr0 : thr1;
      step();
      n_checks++;
      if (valid_out !== emask[i]) begin
        n_errors++;
        $display("FAIL beat_valid pix=%0d got=%b exp=%b", i, valid_out, emask[i]);
      end
      if (emask[i]) begin
        n_checks++;
        if (x_out !== 11'(i % 4) || y_out !== 10'(i / 4)) begin
          n_errors++;
          $display("FAIL beat_xy pix=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                   i, x_out, y_out, i % 4, i / 4);
        end
      end
      n_checks++;
      if (tabulate_out !== 1'b0) begin
        n_errors++;
        $display("FAIL tab_during_frame pix=%0d got=%b exp=0", i, tabulate_out);
      end
    end
    idle_inputs();
  endtask

  task automatic pulse_com_valid();
    com_valid_in = 1'b1;
    step();
    com_valid_in = 1'b0;
    n_checks++;
    if (busy_out !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_release got=%b exp=0", busy_out);
    end
  endtask

  task automatic expect_tab(input string name, input logic [31:0] cnt);
    step();
    n_checks++;
    if (tabulate_out !== 1'b1 || valid_out !== 1'b0 || busy_out !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_tab got tab=%b valid=%b busy=%b exp tab=1 valid=0 busy=1",
               name, tabulate_out, valid_out, busy_out);
    end
    n_checks++;
    if (pixel_count_out !== cnt) begin
      n_errors++;
      $display("FAIL %s_count got=%0d exp=%0d", name, pixel_count_out, cnt);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    n_checks++;
    if ({valid_out, tabulate_out, empty_frame_out, busy_out} !== 4'b0000 ||
        x_out !== 11'd0 || y_out !== 10'd0 || pixel_count_out !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state got v=%b t=%b e=%b b=%b x=%0d y=%0d c=%0d exp all 0",
               valid_out, tabulate_out, empty_frame_out, busy_out, x_out, y_out,
               pixel_count_out);
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    drive_frame(8'd200, 8'd10, 12'h802, 12'h802, 8'd128, 8'd128, 12);
    expect_tab("full", 32'd2);
    step();
    n_checks++;
    if (tabulate_out !== 1'b0 || busy_out !== 1'b1) begin
      n_errors++;
      $display("FAIL full_wait got tab=%b busy=%b exp tab=0 busy=1", tabulate_out, busy_out);
    end
    step();
    step();
    n_checks++;
    if (busy_out !== 1'b1) begin
      n_errors++;
      $display("FAIL full_wait_hold got busy=%b exp=1", busy_out);
    end
    pulse_com_valid();
  endtask

  task automatic test_empty_frame();
    drive_frame(8'd10, 8'd10, 12'h000, 12'h000, 8'd128, 8'd128, 12);
    step();
    n_checks++;
    if (empty_frame_out !== 1'b1 || tabulate_out !== 1'b0 || pixel_count_out !== 32'd0) begin
      n_errors++;
      $display("FAIL empty_pulse got e=%b t=%b c=%0d exp e=1 t=0 c=0",
               empty_frame_out, tabulate_out, pixel_count_out);
    end
    step();
    n_checks++;
    if (empty_frame_out !== 1'b0 || busy_out !== 1'b0 || tabulate_out !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_after got e=%b b=%b t=%b exp 0 0 0",
               empty_frame_out, busy_out, tabulate_out);
    end
  endtask

  task automatic test_holdoff();
    drive_frame(8'd255, 8'd255, 12'hFFF, 12'hFFF, 8'd128, 8'd128, 12);
    expect_tab("hold_first", 32'd12);
    drive_frame(8'd255, 8'd255, 12'hFFF, 12'h000, 8'd128, 8'd128, 12);
    step();
    n_checks++;
    if (tabulate_out !== 1'b0 || valid_out !== 1'b0 || busy_out !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_dropped got t=%b v=%b b=%b exp 0 0 1",
               tabulate_out, valid_out, busy_out);
    end
    pulse_com_valid();
    drive_frame(8'd255, 8'd255, 12'hFFF, 12'hFFF, 8'd128, 8'd128, 12);
    expect_tab("hold_third", 32'd12);
    pulse_com_valid();
  endtask

  task automatic test_truncated();
    drive_frame(8'd200, 8'd10, 12'h0A1, 12'h0A1, 8'd128, 8'd128, 8);
    pixel_valid_in = 1'b1;
    frame_start_in = 1'b1;
    luma_in        = 8'd255;
    step();
    idle_inputs();
    n_checks++;
    if (valid_out !== 1'b0 || tabulate_out !== 1'b0) begin
      n_errors++;
      $display("FAIL trunc_newpix got v=%b t=%b exp 0 0", valid_out, tabulate_out);
    end
    expect_tab("trunc", 32'd3);
    pixel_valid_in = 1'b1;
    luma_in        = 8'd255;
    step();
    step();
    idle_inputs();
    n_checks++;
    if (valid_out !== 1'b0 || busy_out !== 1'b1) begin
      n_errors++;
      $display("FAIL trunc_wait got v=%b b=%b exp 0 1", valid_out, busy_out);
    end
    pulse_com_valid();
  endtask

  task automatic test_threshold();
    drive_frame(8'd200, 8'd100, 12'h842, 12'h842, 8'd128, 8'd50, 12);
    expect_tab("thr_old", 32'd3);
    pulse_com_valid();
    drive_frame(8'd200, 8'd100, 12'h842, 12'hFFF, 8'd50, 8'd50, 12);
    expect_tab("thr_new", 32'd12);
    pulse_com_valid();
  endtask

  task automatic test_reset_mid();
    drive_frame(8'd200, 8'd10, 12'h002, 12'h002, 8'd128, 8'd128, 2);
    rst_in         = 1'b1;
    pixel_valid_in = 1'b1;
    luma_in        = 8'd200;
    step();
    n_checks++;
    if ({valid_out, tabulate_out, empty_frame_out, busy_out} !== 4'b0000 ||
        x_out !== 11'd0 || y_out !== 10'd0 || pixel_count_out !== 32'd0) begin
      n_errors++;
      $display("FAIL midreset got v=%b t=%b e=%b b=%b x=%0d y=%0d c=%0d exp all 0",
               valid_out, tabulate_out, empty_frame_out, busy_out, x_out, y_out,
               pixel_count_out);
    end
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (valid_out !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_ignored i=%0d got=%b exp=0", i, valid_out);
      end
    end
    idle_inputs();
    step();
    n_checks++;
    if (tabulate_out !== 1'b0 || busy_out !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_idle got t=%b b=%b exp 0 0", tabulate_out, busy_out);
    end
    drive_frame(8'd200, 8'd10, 12'h802, 12'h802, 8'd128, 8'd128, 12);
    expect_tab("midreset_next", 32'd2);
    pulse_com_valid();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_empty_frame();
    test_holdoff();
    test_truncated();
    test_threshold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
